// File: rtl/bcd_cnt_ctrl.sv
// Run controller for a 3-digit BCD stopwatch counter: button edges drive a
// start/pause/resume/stop FSM that issues prescaled increment and clear strobes.
module bcd_cnt_ctrl #(
    parameter int          TICK_DIV = 100_000_000,
    parameter int          DIV_W    = 27,
    parameter logic [11:0] LIMIT    = 12'h999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        stop_btn,
    input  logic [11:0] cnt,
    output logic        inc,
    output logic        clr,
    output logic        running,
    output logic        paused,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_start_q;
    logic               r_stop_q;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [DIV_W-1:0]   w_div_nxt;
    logic               w_start_e;
    logic               w_stop_e;
    logic               w_tick;
    logic               w_inc;
    logic               w_clr;

    assign w_start_e = start_btn & ~r_start_q;
    assign w_stop_e  = stop_btn & ~r_stop_q;
    assign w_tick    = (r_div_cnt == DIV_LAST);

    // Next-state, prescaler and strobe decisions; stop always outranks start and tick.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_inc       = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_div_nxt = {DIV_W{1'b0}};
                if (w_stop_e) begin
                    w_clr = 1'b1;
                end else if (w_start_e) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_stop_e) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                    w_div_nxt   = {DIV_W{1'b0}};
                end else if (w_start_e) begin
                    // Prescaler freezes on the pause edge so resume keeps the phase.
                    w_state_nxt = ST_PAUSE;
                end else if (w_tick) begin
                    w_div_nxt = {DIV_W{1'b0}};
                    if (cnt == LIMIT) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_inc = 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + DIV_ONE;
                end
            end
            ST_PAUSE: begin
                if (w_stop_e) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                    w_div_nxt   = {DIV_W{1'b0}};
                end else if (w_start_e) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (w_stop_e) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                    w_div_nxt   = {DIV_W{1'b0}};
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_div_nxt   = {DIV_W{1'b0}};
            end
        endcase
    end

    // State, edge-detect and prescaler registers; button copies reset high to mask held buttons.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b1;
            r_stop_q  <= 1'b1;
            r_div_cnt <= {DIV_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start_btn;
            r_stop_q  <= stop_btn;
            r_div_cnt <= w_div_nxt;
        end
    end

    // Registered outputs so strobes and flags appear one cycle after the decision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inc     <= 1'b0;
            clr     <= 1'b0;
            running <= 1'b0;
            paused  <= 1'b0;
            done    <= 1'b0;
        end else begin
            inc     <= w_inc;
            clr     <= w_clr;
            running <= (w_state_nxt == ST_RUN);
            paused  <= (w_state_nxt == ST_PAUSE);
            done    <= (w_state_nxt == ST_DONE);
        end
    end

endmodule
